// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the MIPS pipeline front end
package mips_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int WORD_BYTES = 4;
  typedef enum logic [1:0] {FETCH, DRAIN, HOLD} fetch_state_t;
endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// ifid_reg: IF/ID pipeline register; clr inserts a bubble while keeping pc_plus4
module ifid_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc_plus4,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        valid
);
  always_ff @(posedge clk) begin
    if (reset) begin
      instr    <= NOP;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (en) begin
      instr    <= clr ? NOP : load_instr;
      pc_plus4 <= clr ? pc_plus4 : load_pc_plus4;
      valid    <= !clr;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, imem handshake with one-entry skid buffer, and IF/ID register.
// Optional FETCH_WAIT_CNT_EN adds a saturating imem wait-cycle counter.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall_d,
  input  logic        pc_src_d,
  input  logic [31:0] pc_branch_d,
  output logic [31:0] instr_d,
  output logic [31:0] pc_plus4_d,
`ifdef FETCH_WAIT_CNT_EN
  output logic [31:0] fetch_wait_cnt,
`endif
  output logic        valid_d
);
  fetch_state_t state, state_n;
  logic [31:0] pc, pc_plus4, target, skid_instr, skid_pc_plus4, drain_addr;
  logic [31:0] load_instr, load_pc_plus4;
  logic redirect, load, unused_bits;
  assign pc_plus4    = pc + 32'(WORD_BYTES);
  assign target      = {pc_branch_d[31:2], 2'b00};
  assign redirect    = pc_src_d && !stall_d;
  assign unused_bits = ^pc_branch_d[1:0];
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else state <= state_n;
  end
  always_comb begin
    state_n = state == DRAIN ? (imem_ack ? FETCH : DRAIN) :
              state == HOLD  ? (stall_d ? HOLD : FETCH) :
              redirect       ? (imem_ack ? FETCH : DRAIN) :
              (imem_ack && stall_d) ? HOLD : FETCH;
  end
  always_comb begin
    imem_req      = !reset && state != HOLD;
    imem_addr     = state == DRAIN ? drain_addr : pc;
    load          = !stall_d && !pc_src_d && ((state == FETCH && imem_ack) || state == HOLD);
    load_instr    = state == HOLD ? skid_instr : imem_rdata;
    load_pc_plus4 = state == HOLD ? skid_pc_plus4 : pc_plus4;
  end
  // The in-flight address is latched so DRAIN completes the original handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_PC;
      skid_instr    <= NOP_INSTR;
      skid_pc_plus4 <= '0;
      drain_addr    <= '0;
    end else begin
      if (redirect) pc <= target;
      else if (state == FETCH && imem_ack) pc <= pc_plus4;
      if (state == FETCH && imem_ack && stall_d) begin
        skid_instr    <= imem_rdata;
        skid_pc_plus4 <= pc_plus4;
      end
      if (state == FETCH && redirect && !imem_ack) drain_addr <= pc;
    end
  end
  ifid_reg #(.NOP(NOP_INSTR)) u_ifid (
    .clk          (clk),
    .reset        (reset),
    .en           (!stall_d),
    .clr          (!load),
    .load_instr   (load_instr),
    .load_pc_plus4(load_pc_plus4),
    .instr        (instr_d),
    .pc_plus4     (pc_plus4_d),
    .valid        (valid_d)
  );
`ifdef FETCH_WAIT_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) fetch_wait_cnt <= '0;
    else if (imem_req && !imem_ack && fetch_wait_cnt != 32'hFFFF_FFFF) fetch_wait_cnt <= fetch_wait_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with a variable-latency memory model
module tb_fetch_stage;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic        clk, reset, imem_req, imem_ack, stall_d, pc_src_d, valid_d;
  logic [31:0] imem_addr, imem_rdata, pc_branch_d, instr_d, pc_plus4_d;
`ifdef FETCH_WAIT_CNT_EN
  logic [31:0] fetch_wait_cnt;
`endif
  logic [63:0] exp[$], obs[$];
  logic [63:0] e, o;
  int lat, wcnt, checks, passed;

  fetch_stage dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall_d(stall_d),
    .pc_src_d(pc_src_d), .pc_branch_d(pc_branch_d), .instr_d(instr_d),
    .pc_plus4_d(pc_plus4_d),
`ifdef FETCH_WAIT_CNT_EN
    .fetch_wait_cnt(fetch_wait_cnt),
`endif
    .valid_d(valid_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory: acks after lat wait cycles, rdata = addr ^ K
  initial begin
    imem_ack = 1'b0; imem_rdata = '0; wcnt = 0;
    forever begin
      @(negedge clk); #1;
      if (reset) begin
        imem_ack = 1'b0; wcnt = 0;
      end else begin
        if (imem_ack) wcnt = 0;
        imem_ack = imem_req && wcnt >= lat;
        if (imem_req && !imem_ack) wcnt++;
      end
      imem_rdata = imem_addr ^ K;
    end
  end

  // decode consumes a word on each valid, unstalled cycle
  initial forever begin
    @(negedge clk); #2;
    if (!reset && valid_d && !stall_d) obs.push_back({instr_d, pc_plus4_d});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic push_exp(input logic [31:0] a);
    logic [31:0] n;
    n = a + 32'd4;
    exp.push_back({a ^ K, n});
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1; stall_d = 1'b0; pc_src_d = 1'b0; pc_branch_d = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    obs.delete(); exp.delete();
  endtask

  task automatic test_reset;
    lat = 0;
    @(negedge clk); reset = 1'b1; #3;
    checks++; if (imem_req !== 1'b0) $display("FAIL reset_req got %b want 0", imem_req); else passed++;
    do_reset; #3;
    checks++; if (imem_req !== 1'b1) $display("FAIL post_reset_req got %b want 1", imem_req); else passed++;
    checks++; if (imem_addr !== 32'h0) $display("FAIL reset_pc got %h want 0", imem_addr); else passed++;
    checks++; if ({instr_d, pc_plus4_d, valid_d} !== 65'h0) $display("FAIL reset_ifid got %h/%h/%b want 0/0/0", instr_d, pc_plus4_d, valid_d); else passed++;
  endtask

  task automatic test_stream;
    lat = 0; do_reset;
    for (int i = 0; i < 6; i++) push_exp(32'(4 * i));
    #3;
    checks++; if (imem_addr !== 32'h0) $display("FAIL stream_addr0 got %h want 0", imem_addr); else passed++;
    @(negedge clk); #3;
    checks++; if (imem_addr !== 32'h4) $display("FAIL stream_addr4 got %h want 4", imem_addr); else passed++;
    checks++; if ({instr_d, pc_plus4_d, valid_d} !== {K, 32'h4, 1'b1}) $display("FAIL stream_first got %h/%h/%b want %h/4/1", instr_d, pc_plus4_d, valid_d, K); else passed++;
    @(negedge clk); #3;
    checks++; if (imem_addr !== 32'h8) $display("FAIL stream_addr8 got %h want 8", imem_addr); else passed++;
    repeat (4) @(negedge clk); #3;
    for (int i = 0; exp.size() > 0; i++) begin
      checks++; e = exp.pop_front();
      if (obs.size() == 0) $display("FAIL stream_word%0d got none want %h", i, e);
      else begin o = obs.pop_front(); if (o !== e) $display("FAIL stream_word%0d got %h want %h", i, o, e); else passed++; end
    end
  endtask

  task automatic test_latency;
    lat = 3; do_reset;
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk); #3;
      checks++; if (valid_d !== 1'b0 || instr_d !== 32'h0) $display("FAIL lat_bubble%0d got %h/%b want 0/0", k, instr_d, valid_d); else passed++;
    end
    @(negedge clk); #3;
    checks++; if (valid_d !== 1'b1 || instr_d !== K) $display("FAIL lat_word0 got %h/%b want %h/1", instr_d, valid_d, K); else passed++;
    repeat (10) @(negedge clk); #3;
    for (int i = 0; exp.size() > 0; i++) begin
      checks++; e = exp.pop_front();
      if (obs.size() == 0) $display("FAIL lat_word%0d got none want %h", i, e);
      else begin o = obs.pop_front(); if (o !== e) $display("FAIL lat_word%0d got %h want %h", i, o, e); else passed++; end
    end
  endtask

  task automatic test_stall;
    lat = 0; do_reset;
    for (int i = 0; i < 6; i++) push_exp(32'(4 * i));
    repeat (2) @(negedge clk);
    stall_d = 1'b1;
    @(negedge clk); #3;
    checks++; if (imem_req !== 1'b0) $display("FAIL hold_req got %b want 0", imem_req); else passed++;
    checks++; if (instr_d !== (32'h4 ^ K)) $display("FAIL hold_ifid got %h want %h", instr_d, 32'h4 ^ K); else passed++;
    repeat (3) @(negedge clk);
    stall_d = 1'b0;
    @(negedge clk); #3;
    checks++; if (instr_d !== (32'h8 ^ K) || valid_d !== 1'b1 || imem_addr !== 32'hC) $display("FAIL skid_out got %h/%b/%h want %h/1/c", instr_d, valid_d, imem_addr, 32'h8 ^ K); else passed++;
    repeat (4) @(negedge clk); #3;
    for (int i = 0; exp.size() > 0; i++) begin
      checks++; e = exp.pop_front();
      if (obs.size() == 0) $display("FAIL stall_word%0d got none want %h", i, e);
      else begin o = obs.pop_front(); if (o !== e) $display("FAIL stall_word%0d got %h want %h", i, o, e); else passed++; end
    end
  endtask

  task automatic test_redirect_drain;
    lat = 3; do_reset;
    push_exp(32'h100); push_exp(32'h104);
    pc_src_d = 1'b1; pc_branch_d = 32'h0000_0103;
    @(negedge clk);
    pc_src_d = 1'b0; #3;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL drain_addr got %b/%h want 1/0", imem_req, imem_addr); else passed++;
    repeat (3) begin
      @(negedge clk); #3;
      checks++; if (valid_d !== 1'b0) $display("FAIL drain_bubble got %b want 0", valid_d); else passed++;
    end
    checks++; if (imem_addr !== 32'h100) $display("FAIL drain_target got %h want 100", imem_addr); else passed++;
    lat = 0;
    repeat (3) @(negedge clk); #3;
    for (int i = 0; exp.size() > 0; i++) begin
      checks++; e = exp.pop_front();
      if (obs.size() == 0) $display("FAIL drain_word%0d got none want %h", i, e);
      else begin o = obs.pop_front(); if (o !== e) $display("FAIL drain_word%0d got %h want %h", i, o, e); else passed++; end
    end
  endtask

  task automatic test_redirect_ack;
    lat = 0; do_reset;
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h40); push_exp(32'h44);
    repeat (2) @(negedge clk);
    pc_src_d = 1'b1; pc_branch_d = 32'h0000_0040;
    @(negedge clk);
    pc_src_d = 1'b0; #3;
    checks++; if (imem_addr !== 32'h40 || valid_d !== 1'b0) $display("FAIL redir_ack got %h/%b want 40/0", imem_addr, valid_d); else passed++;
    repeat (3) @(negedge clk); #3;
    for (int i = 0; exp.size() > 0; i++) begin
      checks++; e = exp.pop_front();
      if (obs.size() == 0) $display("FAIL redir_word%0d got none want %h", i, e);
      else begin o = obs.pop_front(); if (o !== e) $display("FAIL redir_word%0d got %h want %h", i, o, e); else passed++; end
    end
  endtask

  task automatic test_hold_redirect_wrap;
    lat = 0; do_reset;
    push_exp(32'h0); push_exp(32'h4); push_exp(32'hFFFF_FFF8); push_exp(32'hFFFF_FFFC); push_exp(32'h0);
    repeat (2) @(negedge clk);
    stall_d = 1'b1;
    repeat (2) @(negedge clk);
    stall_d = 1'b0; pc_src_d = 1'b1; pc_branch_d = 32'hFFFF_FFF9; #3;
    checks++; if (imem_req !== 1'b0) $display("FAIL wrap_hold_req got %b want 0", imem_req); else passed++;
    @(negedge clk);
    pc_src_d = 1'b0; #3;
    checks++; if (imem_addr !== 32'hFFFF_FFF8 || valid_d !== 1'b0) $display("FAIL wrap_target got %h/%b want fffffff8/0", imem_addr, valid_d); else passed++;
    repeat (4) @(negedge clk); #3;
    for (int i = 0; exp.size() > 0; i++) begin
      checks++; e = exp.pop_front();
      if (obs.size() == 0) $display("FAIL wrap_word%0d got none want %h", i, e);
      else begin o = obs.pop_front(); if (o !== e) $display("FAIL wrap_word%0d got %h want %h", i, o, e); else passed++; end
    end
  endtask

`ifdef FETCH_WAIT_CNT_EN
  task automatic test_wait_cnt;
    lat = 5; do_reset; #3;
    checks++; if (fetch_wait_cnt !== 32'd0) $display("FAIL cnt_reset got %0d want 0", fetch_wait_cnt); else passed++;
    repeat (5) @(negedge clk); #3;
    checks++; if (fetch_wait_cnt !== 32'd5) $display("FAIL cnt_wait got %0d want 5", fetch_wait_cnt); else passed++;
    repeat (3) @(negedge clk);
    reset = 1'b1; #3;
    checks++; if (fetch_wait_cnt !== 32'd7) $display("FAIL cnt_accum got %0d want 7", fetch_wait_cnt); else passed++;
    @(negedge clk);
    reset = 1'b0; #3;
    checks++; if (fetch_wait_cnt !== 32'd0 || imem_addr !== 32'h0 || imem_req !== 1'b1) $display("FAIL cnt_midreset got %0d/%h/%b want 0/0/1", fetch_wait_cnt, imem_addr, imem_req); else passed++;
    lat = 0;
  endtask
`endif

  initial begin
    checks = 0; passed = 0; lat = 0;
    reset = 1'b1; stall_d = 1'b0; pc_src_d = 1'b0; pc_branch_d = '0;
    test_reset;
    test_stream;
    test_latency;
    test_stall;
    test_redirect_drain;
    test_redirect_ack;
    test_hold_redirect_wrap;
`ifdef FETCH_WAIT_CNT_EN
    test_wait_cnt;
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
